// File: rtl/fifo_vpar_pkg.sv
// -----------------------------------------------------------------------------
// fifo_vpar_pkg
// Shared definitions for the variable-parallelism FIFO:
//   - width helpers for counts, occupancy and pointers
//   - wrap_add: modulo-DEPTH pointer advance (DEPTH need not be a power of two)
//   - min_u: unsigned minimum
//   - xfer_t: per-cycle transfer/error decision bundle
// -----------------------------------------------------------------------------
package fifo_vpar_pkg;

  localparam int unsigned DEF_WIDTH     = 32'd16;
  localparam int unsigned DEF_DEPTH     = 32'd8;
  localparam int unsigned DEF_PAR_WRITE = 32'd2;
  localparam int unsigned DEF_PAR_READ  = 32'd4;

  // Per-cycle decisions taken by the handshake logic.
  typedef struct packed {
    logic wr_fire;
    logic rd_fire;
    logic wr_err;
    logic rd_err;
  } xfer_t;

  // Bits needed to hold a count in 0..max_cnt.
  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return (max_cnt < 32'd1) ? 32'd1 : $clog2(max_cnt + 32'd1);
  endfunction

  // Bits needed to address 0..depth-1.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 32'd1) ? 32'd1 : $clog2(depth);
  endfunction

  // Modulo advance by conditional subtract; valid while ptr < depth and inc <= depth.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + inc;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_vpar_mem.sv
// -----------------------------------------------------------------------------
// fifo_vpar_mem
// Element storage for fifo_vpar. PAR_WRITE independent write lanes (enable +
// address each) and PAR_READ combinational read lanes. The array is not reset;
// the top level masks any lane not backed by valid data.
// Ports:
//   clk      clock
//   i_we     per-lane write enable
//   i_waddr  per-lane write address, lane i at [i*PTR_W +: PTR_W]
//   i_wdata  per-lane write data,    lane i at [i*WIDTH +: WIDTH]
//   i_raddr  per-lane read address
//   o_rdata  per-lane read data (combinational)
// -----------------------------------------------------------------------------
module fifo_vpar_mem #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PAR_WRITE = 2,
  parameter int unsigned PAR_READ  = 4,
  parameter int unsigned PTR_W     = 3
) (
  input  logic                         clk,
  input  logic [PAR_WRITE-1:0]         i_we,
  input  logic [PAR_WRITE*PTR_W-1:0]   i_waddr,
  input  logic [PAR_WRITE*WIDTH-1:0]   i_wdata,
  input  logic [PAR_READ*PTR_W-1:0]    i_raddr,
  output logic [PAR_READ*WIDTH-1:0]    o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write lanes; addresses within one cycle are always distinct.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PAR_WRITE; i++) begin
      if (i_we[i]) begin
        r_mem[i_waddr[i*PTR_W +: PTR_W]] <= i_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // Combinational read lanes feeding the show-ahead output.
  always_comb begin
    o_rdata = '0;
    for (int unsigned i = 0; i < PAR_READ; i++) begin
      o_rdata[i*WIDTH +: WIDTH] = r_mem[i_raddr[i*PTR_W +: PTR_W]];
    end
  end

endmodule

// File: rtl/fifo_vpar.sv
// -----------------------------------------------------------------------------
// fifo_vpar
// Multi-lane FIFO: writes 1..PAR_WRITE elements and reads 1..PAR_READ elements
// per cycle with valid/ready handshakes. Show-ahead output, arbitrary DEPTH,
// almost-full/almost-empty thresholds, optional partial reads, sticky
// protocol-error flag.
// Ports:
//   clk, rstn (sync, active-low), clear (sync flush, same effect as reset)
//   in_valid/in_count/din/in_ready   producer side, lane 0 oldest
//   out_valid/out_avail/dout         show-ahead consumer view, lane 0 oldest
//   out_ready/out_take               consumer pop request
//   level, almost_full, almost_empty occupancy status
//   proto_err                        sticky protocol violation
// -----------------------------------------------------------------------------
module fifo_vpar
  import fifo_vpar_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned PAR_WRITE    = DEF_PAR_WRITE,
  parameter int unsigned PAR_READ     = DEF_PAR_READ,
  parameter int unsigned AF_LEVEL     = DEPTH - PAR_WRITE,
  parameter int unsigned AE_LEVEL     = PAR_READ,
  parameter bit          PARTIAL_READ = 1'b1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               clear,
  input  logic                               in_valid,
  input  logic [cnt_width(PAR_WRITE)-1:0]    in_count,
  input  logic [WIDTH*PAR_WRITE-1:0]         din,
  output logic                               in_ready,
  output logic                               out_valid,
  output logic [cnt_width(PAR_READ)-1:0]     out_avail,
  output logic [WIDTH*PAR_READ-1:0]          dout,
  input  logic                               out_ready,
  input  logic [cnt_width(PAR_READ)-1:0]     out_take,
  output logic [cnt_width(DEPTH)-1:0]        level,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic                               proto_err
);

  localparam int unsigned OC_W  = cnt_width(PAR_READ);
  localparam int unsigned LV_W  = cnt_width(DEPTH);
  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LV_W-1:0]  r_level;
  logic             r_proto_err;

  int unsigned w_level_u;
  int unsigned w_free_u;
  int unsigned w_in_cnt_u;
  int unsigned w_take_u;
  int unsigned w_avail_u;
  int unsigned w_wcnt_u;
  int unsigned w_rcnt_u;
  xfer_t       w_xfer;

  logic [PAR_WRITE-1:0]       w_we;
  logic [PAR_WRITE*PTR_W-1:0] w_waddr;
  logic [PAR_READ*PTR_W-1:0]  w_raddr;
  logic [PAR_READ*WIDTH-1:0]  w_rdata;

  // Occupancy view, handshakes and transfer/error decisions from registered state.
  always_comb begin
    w_level_u  = 32'(r_level);
    // Free space ignores a same-cycle read: no read-to-write bypass.
    w_free_u   = DEPTH - w_level_u;
    w_in_cnt_u = 32'(in_count);
    if (PARTIAL_READ) begin
      w_avail_u = min_u(w_level_u, PAR_READ);
      w_take_u  = 32'(out_take);
    end else begin
      w_avail_u = (w_level_u >= PAR_READ) ? PAR_READ : 32'd0;
      w_take_u  = PAR_READ;
    end

    in_ready     = (w_in_cnt_u <= w_free_u) && (w_in_cnt_u <= PAR_WRITE);
    out_valid    = (w_avail_u != 32'd0);
    out_avail    = OC_W'(w_avail_u);
    level        = r_level;
    almost_full  = (w_level_u >= AF_LEVEL);
    almost_empty = (w_level_u < AE_LEVEL);
    proto_err    = r_proto_err;

    w_xfer         = '0;
    w_xfer.wr_err  = in_valid && (w_in_cnt_u > PAR_WRITE);
    w_xfer.wr_fire = in_valid && in_ready && (w_in_cnt_u != 32'd0);
    w_xfer.rd_err  = PARTIAL_READ && out_ready && out_valid && (w_take_u > w_avail_u);
    w_xfer.rd_fire = out_valid && out_ready && (w_take_u != 32'd0) && (w_take_u <= w_avail_u);

    w_wcnt_u = w_xfer.wr_fire ? w_in_cnt_u : 32'd0;
    w_rcnt_u = w_xfer.rd_fire ? w_take_u : 32'd0;
  end

  // Per-lane write enables/addresses and show-ahead read addresses.
  always_comb begin
    w_we    = '0;
    w_waddr = '0;
    w_raddr = '0;
    for (int unsigned i = 0; i < PAR_WRITE; i++) begin
      w_we[i]                   = w_xfer.wr_fire && (i < w_in_cnt_u);
      w_waddr[i*PTR_W +: PTR_W] = PTR_W'(wrap_add(32'(r_wptr), i, DEPTH));
    end
    for (int unsigned i = 0; i < PAR_READ; i++) begin
      w_raddr[i*PTR_W +: PTR_W] = PTR_W'(wrap_add(32'(r_rptr), i, DEPTH));
    end
  end

  // Mask lanes beyond out_avail so stale array contents never leak out.
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < PAR_READ; i++) begin
      if (i < w_avail_u) begin
        dout[i*WIDTH +: WIDTH] = w_rdata[i*WIDTH +: WIDTH];
      end else begin
        dout[i*WIDTH +: WIDTH] = '0;
      end
    end
  end

  // Pointer, occupancy and sticky error state; clear wins over any transfer.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_xfer.wr_fire) begin
        r_wptr <= PTR_W'(wrap_add(32'(r_wptr), w_in_cnt_u, DEPTH));
      end
      if (w_xfer.rd_fire) begin
        r_rptr <= PTR_W'(wrap_add(32'(r_rptr), w_take_u, DEPTH));
      end
      r_level <= LV_W'(w_level_u + w_wcnt_u - w_rcnt_u);
      if (w_xfer.wr_err || w_xfer.rd_err) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  fifo_vpar_mem #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .PAR_WRITE (PAR_WRITE),
    .PAR_READ  (PAR_READ),
    .PTR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (din),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_fifo_vpar.sv
// -----------------------------------------------------------------------------
// tb_fifo_vpar
// Two instances (DEPTH=8 and DEPTH=6) share one directed stimulus stream. Each
// instance has a queue-based reference model and a per-cycle compare process;
// literal expectations pin key points of the default instance.
// -----------------------------------------------------------------------------
module tb_fifo_vpar;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        clear;
  logic        in_valid;
  logic [1:0]  in_count;
  logic [31:0] din;
  logic        out_ready;
  logic [2:0]  out_take;
  bit          chk_en = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : m
    localparam int unsigned D  = (g == 0) ? 8 : 6;
    localparam int unsigned LW = $clog2(D + 1);

    logic          ir, ov, af, ae, perr;
    logic [2:0]    avail;
    logic [63:0]   dout;
    logic [LW-1:0] lvl;
    logic [15:0]   q[$];
    bit            err_m;

    fifo_vpar #(.WIDTH(16), .DEPTH(D), .PAR_WRITE(2), .PAR_READ(4)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .clear        (clear),
      .in_valid     (in_valid),
      .in_count     (in_count),
      .din          (din),
      .in_ready     (ir),
      .out_valid    (ov),
      .out_avail    (avail),
      .dout         (dout),
      .out_ready    (out_ready),
      .out_take     (out_take),
      .level        (lvl),
      .almost_full  (af),
      .almost_empty (ae),
      .proto_err    (perr)
    );

    // Reference model: a plain queue of elements, updated on each clock edge.
    always @(posedge clk) begin
      int avail_m, take_m, cnt_m, free_m;
      if (!rstn || clear) begin
        q.delete();
        err_m = 1'b0;
      end else begin
        avail_m = (q.size() < 4) ? q.size() : 4;
        free_m  = int'(D) - q.size();
        take_m  = 32'(out_take);
        cnt_m   = 32'(in_count);
        if (in_valid && cnt_m > 2) err_m = 1'b1;
        if (out_ready && avail_m > 0 && take_m > avail_m) err_m = 1'b1;
        if (out_ready && avail_m > 0 && take_m > 0 && take_m <= avail_m)
          repeat (take_m) void'(q.pop_front());
        if (in_valid && cnt_m > 0 && cnt_m <= 2 && cnt_m <= free_m)
          for (int k = 0; k < cnt_m; k++) q.push_back(din[16*k +: 16]);
      end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
      int n, c;
      logic [63:0] exp_d;
      if (chk_en) begin
        n = (q.size() < 4) ? q.size() : 4;
        c = 32'(in_count);
        exp_d = '0;
        for (int k = 0; k < n; k++) exp_d[16*k +: 16] = q[k];
        chk($sformatf("d%0d.level", D), 64'(lvl), 64'(q.size()));
        chk($sformatf("d%0d.out_avail", D), 64'(avail), 64'(n));
        chk($sformatf("d%0d.out_valid", D), 64'(ov), 64'(n > 0));
        chk($sformatf("d%0d.dout", D), dout, exp_d);
        chk($sformatf("d%0d.almost_full", D), 64'(af), 64'(q.size() >= int'(D) - 2));
        chk($sformatf("d%0d.almost_empty", D), 64'(ae), 64'(q.size() < 4));
        chk($sformatf("d%0d.in_ready", D), 64'(ir), 64'(c <= int'(D) - q.size() && c <= 2));
        chk($sformatf("d%0d.proto_err", D), 64'(perr), 64'(err_m));
      end
    end
  end

  task automatic idle();
    in_valid  = 1'b0;
    in_count  = 2'd0;
    din       = 32'd0;
    out_ready = 1'b0;
    out_take  = 3'd0;
    clear     = 1'b0;
  endtask

  task automatic step(input bit v, input int c, input logic [15:0] d0, input logic [15:0] d1,
                      input bit r, input int t, input bit cl);
    in_valid  = v;
    in_count  = 2'(c);
    din       = {d1, d0};
    out_ready = r;
    out_take  = 3'(t);
    clear     = cl;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int c, input logic [15:0] d0, input logic [15:0] d1);
    step(1'b1, c, d0, d1, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int t);
    step(1'b0, 0, 16'h0, 16'h0, 1'b1, t, 1'b0);
  endtask

  task automatic clr();
    step(1'b0, 0, 16'h0, 16'h0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn   = 1'b1;
    chk_en = 1'b1;

    // 1: reset state
    in_count = 2'd2;
    #1;
    chk("s1.level", 64'(m[0].lvl), 64'd0);
    chk("s1.out_valid", 64'(m[0].ov), 64'd0);
    chk("s1.almost_empty", 64'(m[0].ae), 64'd1);
    chk("s1.in_ready", 64'(m[0].ir), 64'd1);
    chk("s1.proto_err", 64'(m[0].perr), 64'd0);
    chk("s1.dout", m[0].dout, 64'd0);
    idle();

    // 2: fill to 7, free space limits in_ready
    wr(2, 16'hA0, 16'hA1);
    wr(2, 16'hA2, 16'hA3);
    wr(2, 16'hA4, 16'hA5);
    wr(1, 16'hA6, 16'h0);
    chk("s2.level", 64'(m[0].lvl), 64'd7);
    chk("s2.almost_full", 64'(m[0].af), 64'd1);
    chk("s2.level_d6", 64'(m[1].lvl), 64'd6);
    in_count = 2'd2;
    #1;
    chk("s2.in_ready_cnt2", 64'(m[0].ir), 64'd0);
    in_count = 2'd1;
    #1;
    chk("s2.in_ready_cnt1", 64'(m[0].ir), 64'd1);
    chk("s2.in_ready_cnt1_d6", 64'(m[1].ir), 64'd0);
    idle();

    // 3: partial show-ahead and partial pop
    clr();
    wr(2, 16'h000A, 16'h000B);
    wr(1, 16'h000C, 16'h0);
    chk("s3.out_avail", 64'(m[0].avail), 64'd3);
    chk("s3.dout", m[0].dout, 64'h0000_000C_000B_000A);
    rd(2);
    chk("s3.level_after_pop", 64'(m[0].lvl), 64'd1);
    chk("s3.dout_after_pop", m[0].dout, 64'h0000_0000_0000_000C);

    // 4: pointer wrap for DEPTH=8 and DEPTH=6
    clr();
    wr(2, 16'd1, 16'd2);
    wr(2, 16'd3, 16'd4);
    wr(2, 16'd5, 16'd6);
    rd(4);
    wr(2, 16'd7, 16'd8);
    wr(2, 16'd9, 16'd10);
    wr(2, 16'd11, 16'd12);
    chk("s4.level", 64'(m[0].lvl), 64'd8);
    chk("s4.level_d6", 64'(m[1].lvl), 64'd6);
    chk("s4.dout", m[0].dout, 64'h0008_0007_0006_0005);
    chk("s4.dout_d6", m[1].dout, 64'h0008_0007_0006_0005);
    rd(2);
    chk("s4.dout_wrap", m[0].dout, 64'h000A_0009_0008_0007);
    chk("s4.dout_wrap_d6", m[1].dout, 64'h000A_0009_0008_0007);
    chk("s4.level_d6_after", 64'(m[1].lvl), 64'd4);

    // 5: full, simultaneous write (rejected) and pop of 4
    clr();
    wr(2, 16'h51, 16'h52);
    wr(2, 16'h53, 16'h54);
    wr(2, 16'h55, 16'h56);
    wr(2, 16'h57, 16'h58);
    chk("s5.level_full", 64'(m[0].lvl), 64'd8);
    in_valid  = 1'b1;
    in_count  = 2'd2;
    din       = {16'h5A, 16'h59};
    out_ready = 1'b1;
    out_take  = 3'd4;
    #1;
    chk("s5.in_ready_full", 64'(m[0].ir), 64'd0);
    @(posedge clk);
    #1;
    idle();
    chk("s5.level_after_pop", 64'(m[0].lvl), 64'd4);
    wr(2, 16'h59, 16'h5A);
    chk("s5.level_after_wr", 64'(m[0].lvl), 64'd6);
    chk("s5.dout", m[0].dout, 64'h0058_0057_0056_0055);

    // 6: no-ops, protocol errors, sticky flag, clear
    clr();
    wr(2, 16'h61, 16'h62);
    wr(0, 16'h0, 16'h0);
    rd(0);
    chk("s6.noop_level", 64'(m[0].lvl), 64'd2);
    chk("s6.noop_err", 64'(m[0].perr), 64'd0);
    rd(3);
    chk("s6.rd_err_level", 64'(m[0].lvl), 64'd2);
    chk("s6.rd_err_flag", 64'(m[0].perr), 64'd1);
    wr(3, 16'h63, 16'h64);
    chk("s6.wr_err_level", 64'(m[0].lvl), 64'd2);
    chk("s6.wr_err_flag", 64'(m[0].perr), 64'd1);
    rd(1);
    chk("s6.sticky", 64'(m[0].perr), 64'd1);
    chk("s6.dout_after", m[0].dout, 64'h0000_0000_0000_0062);
    clr();
    chk("s6.clear_err", 64'(m[0].perr), 64'd0);
    chk("s6.clear_level", 64'(m[0].lvl), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_vpar.md
Name: fifo_vpar

Overview:
Multi-lane FIFO that accepts a variable number of elements per cycle (1..PAR_WRITE) and delivers a variable number per cycle (1..PAR_READ), with valid/ready handshakes on both sides.
- Generalises the fixed-count parallel FIFO used in the accelerator datapath.
- Adds per-cycle counts, show-ahead output, non-power-of-two depth, almost-full/almost-empty thresholds, a partial-read mode and protocol-error flags.
- Sits between producer and consumer stages whose lane widths differ.

Parameters:
WIDTH, 16, bits per element
DEPTH, 8, element capacity; any value >= max(PAR_WRITE, PAR_READ), not restricted to powers of two
PAR_WRITE, 2, max elements written per cycle
PAR_READ, 4, max elements read per cycle
AF_LEVEL, DEPTH-PAR_WRITE, almost_full asserted when level >= AF_LEVEL
AE_LEVEL, PAR_READ, almost_empty asserted when level < AE_LEVEL
PARTIAL_READ, 1, 1: output may present fewer than PAR_READ elements; 0: all-or-nothing reads of exactly PAR_READ

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
clear  in  1  synchronous flush, same effect as reset
in_valid  in  1  producer offers in_count elements
in_count  in  $clog2(PAR_WRITE+1)  number of valid lanes in din, packed from lane 0
din  in  WIDTH*PAR_WRITE  lane i = din[i*WIDTH +: WIDTH]; lane 0 is the oldest
in_ready  out  1  write will be accepted this cycle
out_valid  out  1  at least one element (PARTIAL_READ=1) or PAR_READ elements (PARTIAL_READ=0) present
out_avail  out  $clog2(PAR_READ+1)  elements presented on dout
dout  out  WIDTH*PAR_READ  lane 0 = oldest element; lanes >= out_avail driven 0
out_ready  in  1  consumer pops out_take elements
out_take  in  $clog2(PAR_READ+1)  pop count; ignored when PARTIAL_READ=0, where it is forced to PAR_READ
level  out  $clog2(DEPTH+1)  current occupancy
almost_full  out  1  level >= AF_LEVEL
almost_empty  out  1  level < AE_LEVEL
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- State: wptr and rptr in 0..DEPTH-1, and level. All three are registered.
- Reset/clear (clear has priority over any transfer):
  - wptr, rptr and level set to 0; proto_err set to 0.
  - Consequent output values: out_valid=0, out_avail=0, dout=0, almost_full=0 (for AF_LEVEL>0), almost_empty=1 (for AE_LEVEL>0), in_ready=1 for legal in_count.
- Free space: free = DEPTH - level, computed from the registered level only. A read in the same cycle does not free space for a write in that cycle (no bypass).
- in_ready = (in_count <= free) && (in_count <= PAR_WRITE). This is combinational from in_count and level.
- Write fires when in_valid && in_ready && in_count != 0:
  - Lanes 0..in_count-1 are stored at (wptr+i) mod DEPTH.
  - wptr advances by in_count mod DEPTH. Wrap is computed by conditional subtract, never by bit truncation.
- in_count = 0 with in_valid = 1 is a no-op and not an error.
- Output is show-ahead (zero latency from storage):
  - out_avail = min(level, PAR_READ) if PARTIAL_READ=1.
  - out_avail = (level >= PAR_READ) ? PAR_READ : 0 if PARTIAL_READ=0.
  - dout lane i = mem[(rptr+i) mod DEPTH] for i < out_avail.
- Read fires when out_valid && out_ready && take != 0 && take <= out_avail:
  - rptr advances by take mod DEPTH.
  - Written data becomes visible on dout the cycle after the write.
- Level update: level_next = level + wcount - rcount, where wcount and rcount are 0 when the corresponding transfer does not fire. Simultaneous read and write are both applied.
- Protocol errors: in_valid with in_count > PAR_WRITE, or out_ready && out_valid with out_take > out_avail (PARTIAL_READ=1).
  - The offending transfer is dropped.
  - proto_err sets on the next edge and holds until reset or clear.
- almost_full and almost_empty are combinational from the registered level.
- Reset or clear mid-stream discards all stored data. Memory contents are not cleared, but are never exposed because of the out_avail masking.

Decomposition:
- Package fifo_vpar_pkg:
  - clog2-derived width constants;
  - function wrap_add(ptr, inc, DEPTH) returning (ptr+inc) >= DEPTH ? ptr+inc-DEPTH : ptr+inc;
  - function min_u.
- Sub-module fifo_vpar_mem:
  - Storage array with PAR_WRITE write lanes (per-lane enables, per-lane addresses) and PAR_READ combinational read lanes.
  - No reset on the array.
- Top level holds the pointers, level, handshake logic and error flag.

Test Plan:
All scenarios use default parameters.
1. Reset then idle → level=0, out_valid=0, almost_empty=1, in_ready=1 with in_count=2, proto_err=0.
2. Write {A,B} three cycles, then {C} once → level=7, almost_full=1. With in_count=2, in_ready=0 (free=1); with in_count=1, in_ready=1.
3. PARTIAL_READ=1, level=3 with {A,B,C} → out_avail=3, dout lanes 0..2 = A,B,C, lane 3 = 0. Pop out_take=2 → next cycle level=1, dout lane 0 = C.
4. Wrap: fill 6, pop 4 (rptr=4), write 2+2+2 → wptr=6→0→2, level=8, dout order preserved across the wrap. Then repeat with DEPTH=6 and confirm the modulo wrap.
5. Simultaneous: level=8 (full), in_valid with in_count=2 and a pop of 4 in the same cycle → write rejected (in_ready=0), level=4. Next cycle the write is accepted → level=6.
6. out_take=3 with out_avail=2, and separately in_count=3 (widened stimulus) → transfer dropped, level unchanged, proto_err=1 sticky. Assert clear → proto_err=0, level=0.
